// File: rtl/chip_pkg.sv
// Frame geometry and streamer state encoding shared by the CHIP and the
// pixel streamer so both sides agree on beat count and lane width.
package chip_pkg;

  localparam int IMG_DIM    = 20;
  localparam int BIT_LENGTH = 5;
  localparam int LANES      = 5;
  localparam int BEATS      = IMG_DIM * IMG_DIM / LANES;
  localparam int WORD_W     = LANES * BIT_LENGTH;
  localparam int ADDR_W     = 7;

  typedef logic [BIT_LENGTH-1:0] pixel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT_CHIP,
    S_DONE
  } streamer_state_t;

endpackage

// File: rtl/pixel_streamer_if.sv
// Pixel load link between the streamer (master) and the CHIP (slave):
// five pixel lanes, the end-of-frame marker and the CHIP's readable flag.
interface pixel_streamer_if;
  import chip_pkg::*;

  pixel_t pixel_out0;
  pixel_t pixel_out1;
  pixel_t pixel_out2;
  pixel_t pixel_out3;
  pixel_t pixel_out4;
  logic   load_end;
  logic   readable;

  modport master (
    output pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4,
    output load_end,
    input  readable
  );

  modport slave (
    input  pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4,
    input  load_end,
    output readable
  );

endinterface

// File: rtl/pixel_streamer_beat_reg.sv
// Output beat register: aligns frame-buffer read data (one cycle after the
// read strobe) onto the pixel lanes, zero-filling every non-beat cycle.
module stream_beat_reg
  import chip_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              beat_rd,
  input  logic              beat_last,
  input  logic [WORD_W-1:0] rdata,
  output pixel_t            pixel_out0,
  output pixel_t            pixel_out1,
  output pixel_t            pixel_out2,
  output pixel_t            pixel_out3,
  output pixel_t            pixel_out4,
  output logic              load_end
);

  logic valid_d;
  logic last_d;

  // Tracks which cycles carry returning memory data (fixed 1-cycle latency).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_d <= 1'b0;
      last_d  <= 1'b0;
    end else begin
      valid_d <= beat_rd;
      last_d  <= beat_rd && beat_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_out0 <= '0;
      pixel_out1 <= '0;
      pixel_out2 <= '0;
      pixel_out3 <= '0;
      pixel_out4 <= '0;
      load_end   <= 1'b0;
    end else begin
      pixel_out0 <= valid_d ? rdata[0*BIT_LENGTH +: BIT_LENGTH] : '0;
      pixel_out1 <= valid_d ? rdata[1*BIT_LENGTH +: BIT_LENGTH] : '0;
      pixel_out2 <= valid_d ? rdata[2*BIT_LENGTH +: BIT_LENGTH] : '0;
      pixel_out3 <= valid_d ? rdata[3*BIT_LENGTH +: BIT_LENGTH] : '0;
      pixel_out4 <= valid_d ? rdata[4*BIT_LENGTH +: BIT_LENGTH] : '0;
      load_end   <= last_d;
    end
  end

endmodule

// File: rtl/pixel_streamer.sv
// Streams one frame from the frame buffer to the CHIP as contiguous 5-lane
// beats, then waits for the edge result to drain and reports completion.
module pixel_streamer
  import chip_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 4095
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  pixel_streamer_if.master  chip,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [8:0]        edge_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BEATS - 1);
  localparam logic [11:0]       WAIT_LAST = 12'(WAIT_TIMEOUT - 1);

  streamer_state_t state;
  streamer_state_t state_next;
  logic [11:0]     wait_cnt;
  logic            readable_d;
  logic            fell;
  logic            expired;

  // A falling edge needs a high sample from an earlier WAIT_CHIP cycle.
  assign fell    = readable_d && !chip.readable;
  assign expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_addr == LAST_ADDR) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (wait_cnt[0]) state_next = S_WAIT_CHIP;
      end
      S_WAIT_CHIP: begin
        if (fell || expired) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // wait_cnt doubles as the two-cycle drain timer and the WAIT_CHIP timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr   <= '0;
      wait_cnt   <= '0;
      readable_d <= 1'b0;
      edge_count <= '0;
      timeout    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            edge_count <= '0;
            timeout    <= 1'b0;
          end
        end
        S_FETCH: begin
          mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + 1'b1;
        end
        S_DRAIN: begin
          wait_cnt <= wait_cnt[0] ? '0 : wait_cnt + 1'b1;
        end
        S_WAIT_CHIP: begin
          readable_d <= chip.readable;
          wait_cnt   <= wait_cnt + 1'b1;
          if (chip.readable && edge_count != 9'h1FF)
            edge_count <= edge_count + 1'b1;
          if (expired && !fell)
            timeout <= 1'b1;
        end
        S_DONE: begin
          wait_cnt   <= '0;
          readable_d <= 1'b0;
        end
        default: begin
          wait_cnt <= '0;
        end
      endcase
    end
  end

  stream_beat_reg u_beat_reg (
    .clk        (clk),
    .reset      (reset),
    .beat_rd    (mem_rd),
    .beat_last  (mem_addr == LAST_ADDR),
    .rdata      (mem_rdata),
    .pixel_out0 (chip.pixel_out0),
    .pixel_out1 (chip.pixel_out1),
    .pixel_out2 (chip.pixel_out2),
    .pixel_out3 (chip.pixel_out3),
    .pixel_out4 (chip.pixel_out4),
    .load_end   (chip.load_end)
  );

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer: a frame-level reference model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_pixel_streamer;
  import chip_pkg::*;

  localparam int TB_TIMEOUT = 4095;
  localparam int PIXELS     = IMG_DIM * IMG_DIM;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata = '0;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [8:0]        edge_count;

  int n_comp = 0;
  int n_fail = 0;
  int done_count = 0;

  logic [4:0]        img [PIXELS];
  logic [WORD_W-1:0] mem [BEATS];

  pixel_streamer_if chip_if ();

  pixel_streamer #(.WAIT_TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .chip       (chip_if),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  // Synchronous frame buffer with one cycle of read latency.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  always @(negedge clk) if (done === 1'b1) done_count++;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_comp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic fail_bound(input string name);
    n_comp++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired, got no event, expected event", name);
  endtask

  // pattern 1: every pixel of word k is k%32; pattern 2: pixel p is p%32.
  task automatic load_pattern(input int pattern);
    for (int p = 0; p < PIXELS; p++)
      img[p] = (pattern == 1) ? 5'((p / LANES) % 32) : 5'(p % 32);
    for (int k = 0; k < BEATS; k++)
      for (int j = 0; j < LANES; j++)
        mem[k][5*j +: 5] = img[LANES*k + j];
  endtask

  // Reference model: frame timeline counted from the first fetch cycle.
  typedef enum {M_IDLE, M_STREAM, M_WAIT, M_DONE} model_mode_t;
  model_mode_t m_mode = M_IDLE;
  int m_n = 0;
  int m_wait_cycles = 0;
  int m_edges = 0;
  bit m_prev_readable = 1'b0;
  bit m_timeout = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE;
      m_n = 0;
      m_edges = 0;
      m_timeout = 1'b0;
      m_wait_cycles = 0;
      m_prev_readable = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          m_mode = M_STREAM;
          m_n = 0;
          m_edges = 0;
          m_timeout = 1'b0;
        end
        M_STREAM: begin
          if (m_n == BEATS + 1) begin
            m_mode = M_WAIT;
            m_wait_cycles = 0;
            m_prev_readable = 1'b0;
          end else begin
            m_n++;
          end
        end
        M_WAIT: begin
          if (chip_if.readable && m_edges < 511) m_edges++;
          m_wait_cycles++;
          if (m_prev_readable && !chip_if.readable) m_mode = M_DONE;
          else if (m_wait_cycles >= TB_TIMEOUT) begin
            m_timeout = 1'b1;
            m_mode = M_DONE;
          end
          m_prev_readable = chip_if.readable;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [4:0] e_lane [LANES];
    logic [4:0] a_lane [LANES];
    bit e_rd;
    e_rd = (m_mode == M_STREAM) && (m_n < BEATS);
    for (int j = 0; j < LANES; j++) begin
      if (m_mode == M_STREAM && m_n >= 2) e_lane[j] = img[LANES*(m_n-2) + j];
      else                                e_lane[j] = 5'd0;
    end
    a_lane[0] = chip_if.pixel_out0;
    a_lane[1] = chip_if.pixel_out1;
    a_lane[2] = chip_if.pixel_out2;
    a_lane[3] = chip_if.pixel_out3;
    a_lane[4] = chip_if.pixel_out4;
    check_output("busy", 32'(busy), 32'(m_mode != M_IDLE));
    check_output("done", 32'(done), 32'(m_mode == M_DONE));
    check_output("mem_rd", 32'(mem_rd), 32'(e_rd));
    if (e_rd) check_output("mem_addr", 32'(mem_addr), 32'(m_n));
    for (int j = 0; j < LANES; j++)
      check_output($sformatf("pixel_out%0d", j), 32'(a_lane[j]), 32'(e_lane[j]));
    check_output("load_end", 32'(chip_if.load_end), 32'(m_mode == M_STREAM && m_n == BEATS + 1));
    check_output("timeout", 32'(timeout), 32'(m_timeout));
    check_output("edge_count", 32'(edge_count), 32'(m_edges));
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_addr(input int a);
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (mem_rd === 1'b1 && mem_addr === 7'(a)) found = 1'b1;
    end
    if (!found) fail_bound($sformatf("wait_addr_%0d", a));
  endtask

  task automatic wait_done(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
    end
    if (!found) fail_bound("wait_done");
  endtask

  // Holds readable high for high_cycles WAIT_CHIP cycles after load_end.
  task automatic run_drain(input int high_cycles);
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (chip_if.load_end === 1'b1) found = 1'b1;
    end
    if (!found) fail_bound("wait_load_end");
    if (high_cycles > 0) begin
      chip_if.readable = 1'b1;
      repeat (high_cycles + 1) @(posedge clk);
      #2 chip_if.readable = 1'b0;
    end
    wait_done(TB_TIMEOUT + 50);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_base;
    chip_if.readable = 1'b0;
    load_pattern(1);

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_mem_rd", 32'(mem_rd), 32'd0);
    check_output("reset_mem_addr", 32'(mem_addr), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_timeout", 32'(timeout), 32'd0);
    check_output("reset_edge_count", 32'(edge_count), 32'd0);
    check_output("reset_pixel_out0", 32'(chip_if.pixel_out0), 32'd0);
    check_output("reset_load_end", 32'(chip_if.load_end), 32'd0);
    #1 reset = 1'b1;

    $display("[TB] basic frame with 400-cycle drain");
    pulse_start();
    run_drain(400);
    check_output("drain_edge_count", 32'(edge_count), 32'd400);
    check_output("drain_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    check_output("drain_busy_after", 32'(busy), 32'd0);

    $display("[TB] lane mapping and start while busy");
    load_pattern(2);
    pulse_start();
    wait_addr(10);
    repeat (2) @(negedge clk);
    check_output("word10_lane0", 32'(chip_if.pixel_out0), 32'd18);
    check_output("word10_lane2", 32'(chip_if.pixel_out2), 32'd20);
    check_output("word10_lane4", 32'(chip_if.pixel_out4), 32'd22);
    wait_addr(30);
    start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    done_base = done_count;
    run_drain(3);
    repeat (5) @(negedge clk);
    check_output("busy_start_done_pulses", 32'(done_count - done_base), 32'd1);
    check_output("busy_start_edge_count", 32'(edge_count), 32'd3);

    $display("[TB] timeout frame");
    load_pattern(1);
    pulse_start();
    wait_done(BEATS + TB_TIMEOUT + 20);
    @(negedge clk);
    check_output("timeout_flag", 32'(timeout), 32'd1);
    check_output("timeout_edge_count", 32'(edge_count), 32'd0);

    $display("[TB] restart clears timeout, edge_count saturates");
    pulse_start();
    @(negedge clk);
    check_output("restart_timeout_clear", 32'(timeout), 32'd0);
    check_output("restart_busy", 32'(busy), 32'd1);
    run_drain(600);
    check_output("saturated_edge_count", 32'(edge_count), 32'd511);

    $display("[TB] reset mid-frame");
    pulse_start();
    wait_addr(40);
    #2 reset = 1'b0;
    #1;
    check_output("midreset_mem_rd", 32'(mem_rd), 32'd0);
    check_output("midreset_mem_addr", 32'(mem_addr), 32'd0);
    check_output("midreset_busy", 32'(busy), 32'd0);
    check_output("midreset_pixel_out2", 32'(chip_if.pixel_out2), 32'd0);
    check_output("midreset_load_end", 32'(chip_if.load_end), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    $display("[TB] back-to-back frames with start held");
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); @(negedge clk);
    check_output("fresh_mem_rd", 32'(mem_rd), 32'd1);
    check_output("fresh_mem_addr", 32'(mem_addr), 32'd0);
    run_drain(5);
    @(negedge clk);
    check_output("b2b_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_output("b2b_relaunch_rd", 32'(mem_rd), 32'd1);
    check_output("b2b_relaunch_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #2 start = 1'b0;
    run_drain(5);
    check_output("b2b_edge_count", 32'(edge_count), 32'd5);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
    $finish;
  end

endmodule
